// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 32x32 register file, write-back consumer, with a per-register pending-write scoreboard.
// Latency: reads and stall are combinational; regs, pending bits, pending_cnt and orphan_wb update on the rising clk edge.
// Backpressure: stall holds decode on RAW/WAW hazards; optional REGFILE_BYPASS_EN forwards same-cycle write-back data.
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              A_en,
    input  logic              B_en,
    input  logic              issue_valid,
    input  logic              issue_RW,
    input  logic [ADDR_W-1:0] issue_DA,
    output logic [DATA_W-1:0] A_data,
    output logic [DATA_W-1:0] B_data,
    output logic              stall,
    output logic [ADDR_W:0]   pending_cnt,
    output logic              orphan_wb
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [ADDR_W:0]     cnt_nxt;

    logic clr;
    logic clr_hit_a;
    logic clr_hit_b;
    logic clr_hit_w;
    logic byp_a;
    logic byp_b;
    logic haz_a;
    logic haz_b;
    logic haz_w;
    logic accept;
    logic dec;

    assign clr       = writeEnable && (writeReg != '0);
    assign clr_hit_a = clr && (writeReg == AA);
    assign clr_hit_b = clr && (writeReg == BA);
    assign clr_hit_w = clr && (writeReg == issue_DA);

`ifdef REGFILE_BYPASS_EN
    assign byp_a = clr_hit_a;
    assign byp_b = clr_hit_b;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign haz_a = issue_valid && A_en && (AA != '0) && pending[AA] && !byp_a;
    assign haz_b = issue_valid && B_en && (BA != '0) && pending[BA] && !byp_b;
    // A same-edge write-back to the destination retires the old write, so the new one may take its place.
    assign haz_w = issue_valid && issue_RW && (issue_DA != '0) && pending[issue_DA] && !clr_hit_w;
    assign stall = haz_a || haz_b || haz_w;

    assign accept = issue_valid && !stall && issue_RW && (issue_DA != '0);
    assign dec    = clr && pending[writeReg];

    always_comb begin
        A_data = regs[AA];
        if (AA == '0) begin
            A_data = '0;
        end else if (byp_a) begin
            A_data = writeData;
        end
    end

    always_comb begin
        B_data = regs[BA];
        if (BA == '0) begin
            B_data = '0;
        end else if (byp_b) begin
            B_data = writeData;
        end
    end

    // Clear first, then set, so a set on the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (clr) begin
            pending_nxt[writeReg] = 1'b0;
        end
        if (accept) begin
            pending_nxt[issue_DA] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = pending_cnt;
        if (accept && !dec) begin
            cnt_nxt = pending_cnt + CNT_ONE;
        end else if (!accept && dec) begin
            cnt_nxt = pending_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pending     <= '0;
            pending_cnt <= '0;
            orphan_wb   <= 1'b0;
        end else begin
            if (clr) begin
                regs[writeReg] <= writeData;
            end
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
            if (clr && !pending[writeReg]) begin
                orphan_wb <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed scenarios plus randomized traffic against an array/queue reference model.
// Follows REGFILE_BYPASS_EN the same way as the design.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        reset;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
    logic        writeEnable;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic        A_en;
    logic        B_en;
    logic        issue_valid;
    logic        issue_RW;
    logic [4:0]  issue_DA;
    logic [31:0] A_data;
    logic [31:0] B_data;
    logic        stall;
    logic [5:0]  pending_cnt;
    logic        orphan_wb;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_orphan;

    reg_file_scoreboard dut (
        .clk(clk), .reset(reset),
        .writeData(writeData), .writeReg(writeReg), .writeEnable(writeEnable),
        .AA(AA), .BA(BA), .A_en(A_en), .B_en(B_en),
        .issue_valid(issue_valid), .issue_RW(issue_RW), .issue_DA(issue_DA),
        .A_data(A_data), .B_data(B_data), .stall(stall),
        .pending_cnt(pending_cnt), .orphan_wb(orphan_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_clr_hit(input logic [4:0] x);
        return writeEnable && (writeReg != 5'd0) && (writeReg == x);
    endfunction

    function automatic bit m_byp(input logic [4:0] x);
`ifdef REGFILE_BYPASS_EN
        return m_clr_hit(x);
`else
        return (x == 5'd31) && 1'b0;
`endif
    endfunction

    function automatic bit m_stall();
        if (!issue_valid) return 1'b0;
        return (A_en && AA != 0 && m_pend[AA] && !m_byp(AA)) ||
               (B_en && BA != 0 && m_pend[BA] && !m_byp(BA)) ||
               (issue_RW && issue_DA != 0 && m_pend[issue_DA] && !m_clr_hit(issue_DA));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_byp(a)) return writeData;
        return m_regs[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic idle();
        reset = 1'b0; writeData = 32'h0; writeReg = 5'd0; writeEnable = 1'b0;
        AA = 5'd0; BA = 5'd0; A_en = 1'b0; B_en = 1'b0;
        issue_valid = 1'b0; issue_RW = 1'b0; issue_DA = 5'd0;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        bit acc;
        bit clr;
        acc = issue_valid && !m_stall() && issue_RW && issue_DA != 0;
        clr = writeEnable && writeReg != 0;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 1'b0;
            end
            m_orphan = 1'b0;
        end else begin
            if (clr) begin
                if (!m_pend[writeReg]) m_orphan = 1'b1;
                m_regs[writeReg] = writeData;
                m_pend[writeReg] = 1'b0;
            end
            if (acc) m_pend[issue_DA] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1; tick(); idle(); #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %0b want 0", stall); end
        compared++; if (pending_cnt !== 6'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt); end
        compared++; if (orphan_wb !== 1'b0) begin mismatched++; $display("FAIL reset_orphan: got %0b want 0", orphan_wb); end
        for (int i = 0; i < 32; i++) begin
            AA = 5'(i); BA = 5'(31 - i); #1;
            compared++; if (A_data !== 32'h0) begin mismatched++; $display("FAIL reset_read_a[%0d]: got %h want 0", i, A_data); end
            compared++; if (B_data !== 32'h0) begin mismatched++; $display("FAIL reset_read_b[%0d]: got %h want 0", 31 - i, B_data); end
            tick();
        end
    endtask

    task automatic test_r0();
        idle(); writeEnable = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF; tick();
        idle(); #1;
        compared++; if (A_data !== 32'h0) begin mismatched++; $display("FAIL r0_read_a: got %h want 0", A_data); end
        compared++; if (B_data !== 32'h0) begin mismatched++; $display("FAIL r0_read_b: got %h want 0", B_data); end
        compared++; if (orphan_wb !== 1'b0) begin mismatched++; $display("FAIL r0_orphan: got %0b want 0", orphan_wb); end
    endtask

    task automatic test_write_read();
        idle(); writeEnable = 1'b1; writeReg = 5'd5; writeData = 32'hA5A5_A5A5; tick();
        idle(); AA = 5'd5; BA = 5'd5; #1;
        compared++; if (A_data !== 32'hA5A5_A5A5) begin mismatched++; $display("FAIL wr_read_a: got %h want a5a5a5a5", A_data); end
        compared++; if (B_data !== 32'hA5A5_A5A5) begin mismatched++; $display("FAIL wr_read_b: got %h want a5a5a5a5", B_data); end
        compared++; if (orphan_wb !== 1'b1) begin mismatched++; $display("FAIL wr_orphan: got %0b want 1", orphan_wb); end
    endtask

    task automatic test_raw();
        idle(); issue_valid = 1'b1; issue_RW = 1'b1; issue_DA = 5'd10; #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL raw_issue_stall: got %0b want 0", stall); end
        tick();
        idle(); issue_valid = 1'b1; AA = 5'd10; A_en = 1'b1; #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL raw_stall: got %0b want 1", stall); end
        compared++; if (pending_cnt !== 6'd1) begin mismatched++; $display("FAIL raw_cnt: got %0d want 1", pending_cnt); end
        tick();
        writeEnable = 1'b1; writeReg = 5'd10; writeData = 32'h5A5A_5A5A; #1;
`ifdef REGFILE_BYPASS_EN
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL raw_wb_stall: got %0b want 0", stall); end
        compared++; if (A_data !== 32'h5A5A_5A5A) begin mismatched++; $display("FAIL raw_wb_bypass: got %h want 5a5a5a5a", A_data); end
`else
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL raw_wb_stall: got %0b want 1", stall); end
        compared++; if (A_data !== 32'h0) begin mismatched++; $display("FAIL raw_wb_old: got %h want 0", A_data); end
`endif
        tick();
        writeEnable = 1'b0; #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL raw_after_stall: got %0b want 0", stall); end
        compared++; if (A_data !== 32'h5A5A_5A5A) begin mismatched++; $display("FAIL raw_after_data: got %h want 5a5a5a5a", A_data); end
        compared++; if (pending_cnt !== 6'd0) begin mismatched++; $display("FAIL raw_after_cnt: got %0d want 0", pending_cnt); end
        tick();
    endtask

    task automatic test_set_clear_same();
        idle(); issue_valid = 1'b1; issue_RW = 1'b1; issue_DA = 5'd15; tick();
        writeEnable = 1'b1; writeReg = 5'd15; writeData = 32'h0000_1234; #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL same_edge_stall: got %0b want 0", stall); end
        tick();
        idle(); #1;
        compared++; if (pending_cnt !== 6'd1) begin mismatched++; $display("FAIL same_edge_cnt: got %0d want 1", pending_cnt); end
    endtask

    task automatic test_waw();
        idle(); issue_valid = 1'b1; issue_RW = 1'b1; issue_DA = 5'd15; #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL waw_stall: got %0b want 1", stall); end
        tick(); #1;
        compared++; if (pending_cnt !== 6'd1) begin mismatched++; $display("FAIL waw_cnt: got %0d want 1", pending_cnt); end
        idle(); writeEnable = 1'b1; writeReg = 5'd15; tick();
        idle(); #1;
        compared++; if (pending_cnt !== 6'd0) begin mismatched++; $display("FAIL waw_drain_cnt: got %0d want 0", pending_cnt); end
    endtask

    task automatic test_reset_mid();
        idle(); issue_valid = 1'b1; issue_RW = 1'b1; issue_DA = 5'd3; tick();
        issue_DA = 5'd20; tick();
        idle(); #1;
        compared++; if (pending_cnt !== 6'd2) begin mismatched++; $display("FAIL mid_pre_cnt: got %0d want 2", pending_cnt); end
        reset = 1'b1; writeEnable = 1'b1; writeReg = 5'd3; writeData = 32'hDEAD_BEEF;
        issue_valid = 1'b1; issue_RW = 1'b1; issue_DA = 5'd7; tick();
        idle(); #1;
        compared++; if (pending_cnt !== 6'd0) begin mismatched++; $display("FAIL mid_cnt: got %0d want 0", pending_cnt); end
        compared++; if (orphan_wb !== 1'b0) begin mismatched++; $display("FAIL mid_orphan: got %0b want 0", orphan_wb); end
        issue_valid = 1'b1; AA = 5'd3; A_en = 1'b1; BA = 5'd20; B_en = 1'b1; issue_RW = 1'b1; issue_DA = 5'd7; #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL mid_stall: got %0b want 0", stall); end
        compared++; if (A_data !== 32'h0) begin mismatched++; $display("FAIL mid_r3: got %h want 0", A_data); end
        AA = 5'd5; issue_valid = 1'b0; #1;
        compared++; if (A_data !== 32'h0) begin mismatched++; $display("FAIL mid_r5: got %h want 0", A_data); end
        tick();
    endtask

    task automatic test_random();
        int q[$];
        logic [31:0] ea;
        logic [31:0] eb;
        bit          es;
        for (int n = 0; n < 800; n++) begin
            idle();
            reset       = ($urandom_range(0, 99) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_RW    = ($urandom_range(0, 1) == 1);
            issue_DA    = 5'($urandom_range(0, 7));
            A_en        = ($urandom_range(0, 2) != 0);
            B_en        = ($urandom_range(0, 2) != 0);
            AA          = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            BA          = 5'($urandom_range(0, 7));
            writeEnable = ($urandom_range(0, 2) != 0);
            writeData   = $urandom;
            writeReg    = 5'($urandom_range(0, 7));
            if (writeEnable && $urandom_range(0, 4) != 0) begin
                q.delete();
                for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
                if (q.size() > 0) writeReg = 5'(q[$urandom_range(0, q.size() - 1)]);
            end
            #1;
            es = m_stall();
            ea = m_read(AA);
            eb = m_read(BA);
            compared++; if (stall !== es) begin mismatched++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, stall, es); end
            compared++; if (A_data !== ea) begin mismatched++; $display("FAIL rnd_a[%0d]: got %h want %h", n, A_data, ea); end
            compared++; if (B_data !== eb) begin mismatched++; $display("FAIL rnd_b[%0d]: got %h want %h", n, B_data, eb); end
            compared++; if (int'(pending_cnt) !== m_count()) begin mismatched++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, pending_cnt, m_count()); end
            compared++; if (orphan_wb !== m_orphan) begin mismatched++; $display("FAIL rnd_orphan[%0d]: got %0b want %0b", n, orphan_wb, m_orphan); end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_r0();
        test_write_read();
        test_raw();
        test_set_clear_same();
        test_waw();
        test_reset_mid();
        idle(); reset = 1'b1; tick(); idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
